reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 116 +++++++++++
 tb/tb_reg_write_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter owning a shared W-bit register,
// with optional locked bursts of up to MAX_LOCK grants.
module reg_write_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_LOCK = 8,
  localparam int IW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   lock,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           q_valid,
  output logic [IW-1:0]  owner
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [7:0] MAX_C = 8'(MAX_LOCK);

  state_t        state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [7:0]    lock_cnt, cnt_n;
  logic [N-1:0]  gnt_n;
  logic [W-1:0]  q_n;
  logic          qv_n;
  logic [IW-1:0] owner_n;

  logic          hit;
  logic [IW-1:0] win;
  logic [IW-1:0] sel;
  logic [W-1:0]  sel_data;
  logic          keep;
  int            j;

  // Scan downward so the smallest offset from ptr wins.
  always_comb begin
    hit = 1'b0;
    win = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        hit = 1'b1;
        win = IW'(j);
      end
    end
  end

  assign keep = (state == OWN) && req[owner] &&
                lock[owner] && (lock_cnt < MAX_C);

  assign sel = keep ? owner : win;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == IW'(i)) sel_data = wdata[i*W +: W];
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = lock_cnt;
    gnt_n   = '0;
    q_n     = q;
    qv_n    = 1'b0;
    owner_n = owner;
    if (keep) begin
      gnt_n = N'(1) << sel;
      q_n   = sel_data;
      qv_n  = 1'b1;
      cnt_n = lock_cnt + 8'd1;
    end else begin
      state_n = IDLE;
      cnt_n   = '0;
      if (hit) begin
        gnt_n   = N'(1) << sel;
        q_n     = sel_data;
        qv_n    = 1'b1;
        owner_n = win;
        ptr_n   = (win == IW'(N - 1)) ? '0 : win + IW'(1);
        if (lock[win]) begin
          state_n = OWN;
          cnt_n   = 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      lock_cnt <= '0;
      gnt      <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      owner    <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      lock_cnt <= cnt_n;
      gnt      <= gnt_n;
      q        <= q_n;
      q_valid  <= qv_n;
      owner    <= owner_n;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (N=4, W=8,
// MAX_LOCK=8) with immediate-assertion checks.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  lock = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  owner;

  int total = 0;
  int passed = 0;

  reg_write_arbiter #(.N(4), .W(8), .MAX_LOCK(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
    .wdata(wdata), .gnt(gnt), .q(q), .q_valid(q_valid),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input string tag,
                       input logic [3:0] g,
                       input logic [7:0] d,
                       input logic [1:0] o);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_q"}, 32'(q), 32'(d));
    chk({tag, "_qv"}, 32'(q_valid), 32'd1);
    chk({tag, "_own"}, 32'(owner), 32'(o));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qv", 32'(q_valid), 32'h0);
    chk("rst_own", 32'(owner), 32'h0);
    rst_n = 1'b1;

    // round robin across all four
    req = 4'b1111;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    tick(); grant("rr0", 4'b0001, 8'h10, 2'd0);
    tick(); grant("rr1", 4'b0010, 8'h11, 2'd1);
    tick(); grant("rr2", 4'b0100, 8'h12, 2'd2);
    tick(); grant("rr3", 4'b1000, 8'h13, 2'd3);
    tick(); grant("rr4", 4'b0001, 8'h10, 2'd0);

    // idle gap, ptr is now 1
    req = 4'b0001;
    wdata = {8'h13, 8'h12, 8'h11, 8'h5C};
    tick(); grant("gap_w", 4'b0001, 8'h5C, 2'd0);
    req = 4'b0000;
    tick();
    chk("gap_gnt", 32'(gnt), 32'h0);
    chk("gap_qv", 32'(q_valid), 32'h0);
    chk("gap_q", 32'(q), 32'h5C);
    tick();
    chk("gap2_q", 32'(q), 32'h5C);
    req = 4'b1111;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    tick(); grant("gap_ptr", 4'b0010, 8'h11, 2'd1);

    // single requester
    req = 4'b0100;
    wdata = {8'h13, 8'hA5, 8'h11, 8'h10};
    for (int i = 0; i < 3; i++) begin
      tick(); grant("single", 4'b0100, 8'hA5, 2'd2);
    end

    // steer ptr to 1
    req = 4'b1000;
    tick(); grant("st3", 4'b1000, 8'h13, 2'd3);
    req = 4'b0001;
    tick(); grant("st0", 4'b0001, 8'h10, 2'd0);

    // full locked burst by requester 1
    req = 4'b1111;
    lock = 4'b0010;
    wdata = {8'h13, 8'h12, 8'h21, 8'h10};
    for (int i = 0; i < 8; i++) begin
      tick(); grant("burst", 4'b0010, 8'h21, 2'd1);
    end
    tick(); grant("burst_end", 4'b0100, 8'h12, 2'd2);

    // early release by requester 0, ptr is 3
    req = 4'b0001;
    lock = 4'b0001;
    tick(); grant("er1", 4'b0001, 8'h10, 2'd0);
    req = 4'b1001;
    tick(); grant("er2", 4'b0001, 8'h10, 2'd0);
    tick(); grant("er3", 4'b0001, 8'h10, 2'd0);
    lock = 4'b0000;
    tick(); grant("er_exit", 4'b1000, 8'h13, 2'd3);
    tick(); grant("er_idle", 4'b0001, 8'h10, 2'd0);

    // reset in the middle of a burst, ptr is 1
    req = 4'b1111;
    lock = 4'b0010;
    tick(); grant("mr1", 4'b0010, 8'h21, 2'd1);
    tick(); grant("mr2", 4'b0010, 8'h21, 2'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_gnt", 32'(gnt), 32'h0);
    chk("mr_q", 32'(q), 32'h0);
    chk("mr_qv", 32'(q_valid), 32'h0);
    chk("mr_own", 32'(owner), 32'h0);
    #1 rst_n = 1'b1;
    req = 4'b1110;
    lock = 4'b0000;
    tick(); grant("post_rst", 4'b0010, 8'h21, 2'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
